// File: rtl/delay_latency_probe.sv
// delay_latency_probe: measures round-trip latency through an external path by
// flushing it with zeros, launching a one-cycle marker word and counting cycles
// until the marker comes back. Also reports TARGET_LAT-1-latency saturated to
// 0..15 as a compensation tap setting for a downstream delay line.
// Optional macro DELAY_LATENCY_PROBE_VERIFY_EN: run the measurement twice and
// only report done when both passes agree (err otherwise).
module delay_latency_probe #(
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = 8,
  parameter int TIMEOUT      = 255,
  parameter int FLUSH_CYCLES = 16,
  parameter int TARGET_LAT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic [DATA_WIDTH-1:0] probe_out,
  input  logic [DATA_WIDTH-1:0] echo_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  latency,
  output logic [3:0]            comp_delay
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0]        FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C  = CNT_WIDTH'(TIMEOUT);
  localparam logic signed [CNT_WIDTH:0] TGT_M1   = (CNT_WIDTH + 1)'(TARGET_LAT - 1);
  localparam logic signed [CNT_WIDTH:0] COMP_MAX = (CNT_WIDTH + 1)'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SEND,
    S_WAIT,
    S_DONE,
    S_FAIL
  } state_t;

  state_t                 state, next_state;
  logic [DATA_WIDTH-1:0]  pat_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [FW-1:0]          fcnt_q;
  logic                   match;
  logic                   accept;
  logic                   probing;

`ifdef DELAY_LATENCY_PROBE_VERIFY_EN
  logic                   pass2_q;
  logic [CNT_WIDTH-1:0]   lat1_q;
`endif

  // Compensation = TARGET_LAT-1-latency as a signed subtraction, clamped to 0..15.
  function automatic logic [3:0] sat_comp(input logic [CNT_WIDTH-1:0] lat);
    logic signed [CNT_WIDTH:0] diff;
    diff = TGT_M1 - $signed({1'b0, lat});
    if (diff[CNT_WIDTH])
      return 4'd0;
    else if (diff > COMP_MAX)
      return 4'd15;
    else
      return diff[3:0];
  endfunction

  assign match   = (echo_in == pat_q);
  assign accept  = (state == S_IDLE) && start;
  // The marker cycle itself (SEND) is already compared, so a wire loop reads 0.
  assign probing = (state == S_SEND) || (state == S_WAIT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // Next-state logic; a match on the timeout cycle still counts as a match.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start)
          next_state = (pattern == '0) ? S_FAIL : S_FLUSH;
      end
      S_FLUSH: begin
        if (fcnt_q == FLUSH_LAST)
          next_state = S_SEND;
      end
      S_SEND, S_WAIT: begin
        if (match) begin
`ifdef DELAY_LATENCY_PROBE_VERIFY_EN
          if (!pass2_q)
            next_state = S_FLUSH;
          else if (cnt_q == lat1_q)
            next_state = S_DONE;
          else
            next_state = S_FAIL;
`else
          next_state = S_DONE;
`endif
        end else if (cnt_q == TIMEOUT_C) begin
          next_state = S_FAIL;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_DONE, S_FAIL: next_state = S_IDLE;
      default:        next_state = S_IDLE;
    endcase
  end

  // Marker latch, flush length counter and latency counter (cnt is 0 on the marker cycle).
  always_ff @(posedge clk) begin
    if (accept)
      pat_q <= pattern;
    if (state == S_FLUSH)
      fcnt_q <= fcnt_q + 1'b1;
    else
      fcnt_q <= '0;
    if (state == S_FLUSH)
      cnt_q <= '0;
    else if (probing)
      cnt_q <= cnt_q + 1'b1;
  end

`ifdef DELAY_LATENCY_PROBE_VERIFY_EN
  // First-pass bookkeeping: remember which pass we are in and its latency.
  always_ff @(posedge clk) begin
    if (rst)
      pass2_q <= 1'b0;
    else if (accept)
      pass2_q <= 1'b0;
    else if (probing && match && !pass2_q)
      pass2_q <= 1'b1;
    if (probing && match && !pass2_q)
      lat1_q <= cnt_q;
  end
`endif

  // Registered outputs, decoded from the upcoming state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      probe_out  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      latency    <= '0;
      comp_delay <= 4'd0;
    end else begin
      probe_out <= (next_state == S_SEND) ? pat_q : '0;
      busy      <= (next_state != S_IDLE);
      done      <= (next_state == S_DONE);
      err       <= (next_state == S_FAIL);
      if (next_state == S_DONE) begin
        latency    <= cnt_q;
        comp_delay <= sat_comp(cnt_q);
      end
    end
  end

endmodule

// File: doc/delay_latency_probe.md
Name: delay_latency_probe

Overview:
- Measures round-trip latency through an external delayed path, e.g. a programmable SRL-based delay line or a fabric pipeline.
- Drives a one-cycle marker word onto the path, counts cycles until the marker returns, and reports the latency.
- Also reports the compensation delay needed to reach a target latency; downstream logic writes that value into a delay line's 4-bit tap select.

Parameters:
- DATA_WIDTH, 32, width of probe and echo words.
- CNT_WIDTH, 8, width of latency counter and latency output.
- TIMEOUT, 255, max cycles waited for echo before aborting (must be < 2^CNT_WIDTH).
- FLUSH_CYCLES, 16, cycles of all-zero drive before the marker (clears stale path contents).
- TARGET_LAT, 16, desired total latency used for compensation.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a measurement.
- pattern  input  DATA_WIDTH  marker word; sampled on accepted start.
- probe_out  output  DATA_WIDTH  registered drive into the measured path.
- echo_in  input  DATA_WIDTH  output of the measured path.
- busy  output  1  high from accepted start until done/err pulse cycle inclusive.
- done  output  1  one-cycle pulse: latency valid.
- err  output  1  one-cycle pulse: timeout or illegal pattern.
- latency  output  CNT_WIDTH  measured latency, held until next done.
- comp_delay  output  4  TARGET_LAT-1-latency saturated to [0,15], held with latency.

Behaviour:
- Reset:
  - All outputs are 0 one cycle after rst is high; the FSM goes to IDLE.
  - rst mid-measurement aborts immediately, with no done/err pulse.
- States:
  - IDLE: start=1 and busy=0 accepts the request: latch pattern into pat_q and go to FLUSH. If the sampled pattern==0, pulse err the next cycle and return to IDLE, with no FLUSH.
  - FLUSH: probe_out=0 for exactly FLUSH_CYCLES cycles, then SEND.
  - SEND: probe_out=pat_q for exactly one cycle (cycle T0); cnt=0; go to WAIT.
  - WAIT:
    - probe_out=0; cnt increments each cycle.
    - Compare echo_in==pat_q every cycle from T0 onward, including T0 itself.
    - Match at cycle T0+k sets latency=k and goes to DONE.
    - If cnt reaches TIMEOUT with no match, go to FAIL.
  - DONE: done=1 for one cycle; latency and comp_delay update in the same cycle; return to IDLE.
  - FAIL: err=1 for one cycle; latency and comp_delay keep their previous values; return to IDLE.
- Latency definition:
  - Wire loop echo_in=probe_out gives latency 0.
  - An external delay line with tap d (dout = din delayed d+1) gives latency d+1.
- comp_delay arithmetic:
  - Computed as a CNT_WIDTH+1 signed subtraction.
  - Negative result → 0; result >15 → 15.
- start while busy is ignored, with no queuing.
- A partial match (any bit mismatch) is not a match.
- Echo arriving at exactly cnt==TIMEOUT counts as a match; match wins over timeout.
- busy deasserts the cycle after the done/err pulse.

Optional Feature:
- Macro: DELAY_LATENCY_PROBE_VERIFY_EN.
- Defined:
  - After the first match, the FSM repeats FLUSH/SEND/WAIT once more.
  - done pulses only if both latencies are equal.
  - If they differ, err pulses and latency is left unchanged.
  - busy spans both passes.
- Undefined: single pass as described above, with no extra state or logic.

Test Plan:
- Wire loop, pattern=0xA5A5A5A5, start → done after 16+1+1 cycles of busy; latency=0, comp_delay=15.
- External delay_line with tap 4, TARGET_LAT=16 → latency=5, comp_delay=10; tap 15 → latency=16, comp_delay=0 (saturation).
- No echo (echo_in tied 0) → err pulse when cnt=255; latency/comp_delay unchanged from previous run; busy low next cycle.
- pattern=0 with start → err one cycle after start, probe_out never nonzero; start asserted during busy of a valid run → ignored, single done.
- rst asserted mid-WAIT → next cycle all outputs 0, no done/err; a new start then measures correctly.
- With DELAY_LATENCY_PROBE_VERIFY_EN: tap changed 3→6 between the two passes → err, latency retains prior value; stable tap 2 → done, latency=3.
